// File: rtl/ff_load_rr_scheduler.sv
// ff_load_rr_scheduler: round-robin owner of a shared load-enabled register; optional LOAD_LOCK_EN adds lock_in to hold a grant for back-to-back loads
module ff_load_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int COOLDOWN = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset_in,
  input  logic [N_REQ-1:0]         req_in,
  input  logic [N_REQ*WIDTH-1:0]   data_in,
`ifdef LOAD_LOCK_EN
  input  logic [N_REQ-1:0]         lock_in,
`endif
  output logic [N_REQ-1:0]         gnt_out,
  output logic [N_REQ-1:0]         ack_out,
  output logic                     en_out,
  output logic [WIDTH-1:0]         d_out,
  output logic [WIDTH-1:0]         q_out
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;
  localparam logic [N_REQ-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;
  state_t           r_state;
  logic [PW-1:0]    r_ptr, r_win, w_sel;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [WIDTH-1:0] r_q, w_d;
  logic             w_load, w_lock;
  assign w_load  = (r_state == GRANT) && req_in[r_win] && !reset_in;
  assign w_d     = w_load ? data_in[r_win*WIDTH +: WIDTH] : '0;
`ifdef LOAD_LOCK_EN
  assign w_lock  = lock_in[r_win];
`else
  assign w_lock  = 1'b0;
`endif
  assign en_out  = w_load;
  assign d_out   = w_d;
  assign ack_out = w_load ? ONE << r_win : '0;
  assign gnt_out = r_gnt;
  assign q_out   = r_q;
  // first requester at or after the pointer, wrapping; the lowest offset wins
  always_comb begin
    w_sel = r_ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_in[PW'((int'(r_ptr) + k) % N_REQ)]) w_sel = PW'((int'(r_ptr) + k) % N_REQ);
  end
  // scheduler FSM plus the shared register it feeds
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_q     <= RESET_VAL;
    end else begin
      case (r_state)
        IDLE: begin
          r_win   <= w_sel;
          r_gnt   <= |req_in ? ONE << w_sel : '0;
          r_state <= |req_in ? GRANT : IDLE;
        end
        GRANT: begin
          if (w_load) r_q <= w_d;
          if (!(w_load && w_lock)) begin
            r_gnt   <= '0;
            r_state <= IDLE;
            if (w_load) begin
              r_ptr <= r_win == PW'(N_REQ - 1) ? '0 : r_win + 1'b1;
              if (COOLDOWN > 0) begin
                r_state <= COOL;
                r_cnt   <= CW'(COOLDOWN - 1);
              end
            end
          end
        end
        COOL: begin
          r_cnt   <= r_cnt - 1'b1;
          r_state <= r_cnt == '0 ? IDLE : COOL;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
